// File: rtl/cntr_seq_if.sv
// Control/observation bundle for cntr_seq: start/stop/mode/tc in, count/busy/done out.
// Run-count outputs n_* exist only when CNTR_SEQ_RUNCNT_EN is defined.
interface cntr_seq_if;
  logic start;
  logic stop;
  logic mode;
  logic tc_3_, tc_2_, tc_1_, tc_0_;
  logic o_3_, o_2_, o_1_, o_0_;
  logic busy;
  logic done;
`ifdef CNTR_SEQ_RUNCNT_EN
  logic n_3_, n_2_, n_1_, n_0_;
`endif

  modport master (
    output start, stop, mode, tc_3_, tc_2_, tc_1_, tc_0_,
    input  o_3_, o_2_, o_1_, o_0_, busy, done
`ifdef CNTR_SEQ_RUNCNT_EN
    , input n_3_, n_2_, n_1_, n_0_
`endif
  );

  modport slave (
    input  start, stop, mode, tc_3_, tc_2_, tc_1_, tc_0_,
    output o_3_, o_2_, o_1_, o_0_, busy, done
`ifdef CNTR_SEQ_RUNCNT_EN
    , output n_3_, n_2_, n_1_, n_0_
`endif
  );
endinterface

// File: rtl/cntr_seq.sv
// Counter sequencer: IDLE/RUN/GAP control of a 4-bit count against a captured terminal count.
// Optional CNTR_SEQ_RUNCNT_EN adds a saturating completed-run counter on n_3_..n_0_.
module cntr_seq #(
  parameter int TC_DEFAULT = 15,
  parameter int GAP        = 2
) (
  input  logic      c,
  input  logic      r,
  cntr_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_tc, w_tc_nxt;
  logic [3:0] r_gap, w_gap_nxt;
  logic       r_mode, w_mode_nxt;
  logic       r_busy, r_done, w_done_nxt;
  logic [3:0] w_tc_in;
  logic       w_start_acc;

  assign w_tc_in     = {bus.tc_3_, bus.tc_2_, bus.tc_1_, bus.tc_0_};
  assign w_start_acc = (r_state == S_IDLE) && bus.start && !bus.stop;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tc_nxt    = r_tc;
    w_mode_nxt  = r_mode;
    w_gap_nxt   = r_gap;
    case (r_state)
      S_IDLE: begin
        if (w_start_acc) begin
          w_tc_nxt    = w_tc_in;
          w_mode_nxt  = bus.mode;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt != r_tc) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end else if (!r_mode) begin
          w_state_nxt = S_IDLE;
        end else if (GAP > 0) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = 4'(GAP - 1);
        end else begin
          w_cnt_nxt = 4'd0;
        end
      end
      S_GAP: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_gap == 4'd0) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_RUN;
        end else begin
          w_gap_nxt = r_gap - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // done marks arrival at terminal count while the run continues
    w_done_nxt = (w_state_nxt == S_RUN) && (w_cnt_nxt == w_tc_nxt);
  end

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_tc    <= 4'(TC_DEFAULT);
      r_mode  <= 1'b0;
      r_gap   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tc    <= w_tc_nxt;
      r_mode  <= w_mode_nxt;
      r_gap   <= w_gap_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign {bus.o_3_, bus.o_2_, bus.o_1_, bus.o_0_} = r_cnt;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

`ifdef CNTR_SEQ_RUNCNT_EN
  logic [3:0] r_runs;

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      r_runs <= 4'd0;
    end else if (w_start_acc) begin
      r_runs <= 4'd0;
    end else if (r_done && (r_runs != 4'hF)) begin
      r_runs <= r_runs + 4'd1;
    end
  end

  assign {bus.n_3_, bus.n_2_, bus.n_1_, bus.n_0_} = r_runs;
`endif

endmodule

// File: tb/tb_cntr_seq.sv
// Bench for cntr_seq: GAP=2 and GAP=0 instances driven in lockstep, directed table plus random run.
module tb_cntr_seq;
  localparam int G0 = 2;
  localparam int G1 = 0;

  logic c = 1'b0;
  logic r = 1'b0;
  logic       t_start = 1'b0, t_stop = 1'b0, t_mode = 1'b0;
  logic [3:0] t_tc = 4'd0;

  int vecs = 0;
  int errs = 0;

  always #5 c = ~c;

  cntr_seq_if bus0();
  cntr_seq_if bus1();

  assign bus0.start = t_start;
  assign bus0.stop  = t_stop;
  assign bus0.mode  = t_mode;
  assign {bus0.tc_3_, bus0.tc_2_, bus0.tc_1_, bus0.tc_0_} = t_tc;
  assign bus1.start = t_start;
  assign bus1.stop  = t_stop;
  assign bus1.mode  = t_mode;
  assign {bus1.tc_3_, bus1.tc_2_, bus1.tc_1_, bus1.tc_0_} = t_tc;

  cntr_seq #(.TC_DEFAULT(15), .GAP(G0)) dut0 (.c(c), .r(r), .bus(bus0));
  cntr_seq #(.TC_DEFAULT(15), .GAP(G1)) dut1 (.c(c), .r(r), .bus(bus1));

  wire [3:0] o0 = {bus0.o_3_, bus0.o_2_, bus0.o_1_, bus0.o_0_};
  wire [3:0] o1 = {bus1.o_3_, bus1.o_2_, bus1.o_1_, bus1.o_0_};
`ifdef CNTR_SEQ_RUNCNT_EN
  wire [3:0] n0 = {bus0.n_3_, bus0.n_2_, bus0.n_1_, bus0.n_0_};
  wire [3:0] n1 = {bus1.n_3_, bus1.n_2_, bus1.n_1_, bus1.n_0_};
`endif

  // Reference: a run is "active" counting 0..tc, then either ends or holds at tc for 'hold' cycles.
  typedef struct {
    bit act;
    int cnt;
    int tc;
    bit mode;
    int hold;
    bit done;
    int runs;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.act = 0; m.cnt = 0; m.tc = 15; m.mode = 0; m.hold = 0; m.done = 0; m.runs = 0;
    return m;
  endfunction

  function automatic mdl_t step(mdl_t m, bit st, bit sp, bit md, int tcin, int gap);
    mdl_t n = m;
    n.runs = (m.done && m.runs < 15) ? m.runs + 1 : m.runs;
    n.done = 0;
    if (!m.act) begin
      if (st && !sp) begin
        n.tc = tcin; n.mode = md; n.cnt = 0; n.act = 1; n.hold = gap;
        n.done = (tcin == 0); n.runs = 0;
      end
    end else if (sp) begin
      n.act = 0;
    end else if (m.cnt != m.tc) begin
      n.cnt = (m.cnt + 1) % 16;
      n.done = (n.cnt == m.tc);
    end else if (!m.mode) begin
      n.act = 0;
    end else if (m.hold > 0) begin
      n.hold = m.hold - 1;
    end else begin
      n.cnt = 0; n.hold = gap; n.done = (m.tc == 0);
    end
    return n;
  endfunction

  task automatic chk(string nm, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_models();
    chk("g2_o",    int'(o0),        m0.cnt);
    chk("g2_busy", int'(bus0.busy), int'(m0.act));
    chk("g2_done", int'(bus0.done), int'(m0.done));
    chk("g0_o",    int'(o1),        m1.cnt);
    chk("g0_busy", int'(bus1.busy), int'(m1.act));
    chk("g0_done", int'(bus1.done), int'(m1.done));
`ifdef CNTR_SEQ_RUNCNT_EN
    chk("g2_runs", int'(n0), m0.runs);
    chk("g0_runs", int'(n1), m1.runs);
`endif
  endtask

  // One clock: advance models from current inputs, then sample DUTs 1 unit after the edge.
  task automatic cyc();
    m0 = step(m0, t_start, t_stop, t_mode, int'(t_tc), G0);
    m1 = step(m1, t_start, t_stop, t_mode, int'(t_tc), G1);
    @(posedge c);
    #1;
    chk_models();
  endtask

  task automatic drive(bit st, bit sp, bit md, int tcv);
    t_start = st; t_stop = sp; t_mode = md; t_tc = 4'(tcv);
  endtask

  // Mid-cycle asynchronous reset with immediate check, released before the next edge.
  task automatic pulse_reset();
    drive(0, 0, 0, 0);
    #2;
    r = 1'b1;
    #1;
    m0 = mdl_reset();
    m1 = mdl_reset();
    chk("rst_o",    int'(o0),        0);
    chk("rst_busy", int'(bus0.busy), 0);
    chk("rst_done", int'(bus0.done), 0);
    chk("rst_o_g0", int'(o1),        0);
    r = 1'b0;
  endtask

  typedef struct {
    bit st; bit sp; bit md; int tc;
    int eo; bit eb; bit ed;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit st, bit sp, bit md, int tc, int eo, bit eb, bit ed);
    vec_t v;
    v.st = st; v.sp = sp; v.md = md; v.tc = tc; v.eo = eo; v.eb = eb; v.ed = ed;
    tbl.push_back(v);
  endfunction

  initial begin
    bit found;
    // one-shot tc=5
    add(1, 0, 0, 5, 0, 1, 0);
    for (int i = 1; i <= 4; i++) add(0, 0, 0, 0, i, 1, 0);
    add(0, 0, 0, 0, 5, 1, 1);
    add(0, 0, 0, 0, 5, 0, 0);
    add(0, 0, 0, 0, 5, 0, 0);
    // continuous tc=3 with a 2-cycle gap
    add(1, 0, 1, 3, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 3, 1, 1);
    add(0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 3, 1, 1);
    add(1, 0, 1, 0, 3, 1, 0);   // start while busy is ignored
    add(0, 1, 0, 0, 3, 0, 0);   // stop during gap
    // abort at 7 of a tc=12 run, start alongside stop ignored
    add(1, 0, 0, 12, 0, 1, 0);
    for (int i = 1; i <= 7; i++) add(0, 0, 0, 0, i, 1, 0);
    add(1, 1, 0, 12, 7, 0, 0);
    add(1, 0, 0, 12, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    // tc=0 one-shot, then start+stop in idle
    add(1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 3, 0, 0, 0);

    m0 = mdl_reset();
    m1 = mdl_reset();
    @(posedge c);
    #1;
    pulse_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].sp, tbl[i].md, tbl[i].tc);
      cyc();
      chk($sformatf("tbl%0d_o", i),    int'(o0),        tbl[i].eo);
      chk($sformatf("tbl%0d_busy", i), int'(bus0.busy), int'(tbl[i].eb));
      chk($sformatf("tbl%0d_done", i), int'(bus0.done), int'(tbl[i].ed));
    end

    // GAP=0 continuous with tc=0: done every cycle, count stays 0
    drive(1, 0, 1, 0);
    cyc();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("g0_tc0_o",    int'(o1),        0);
      chk("g0_tc0_done", int'(bus1.done), 1);
      chk("g0_tc0_busy", int'(bus1.busy), 1);
      cyc();
    end
    drive(0, 1, 0, 0);
    cyc();

    // async reset while continuous run sits at 9
    drive(1, 0, 1, 12);
    cyc();
    drive(0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (o0 == 4'd9) found = 1;
      else cyc();
    end
    chk("reach_9", int'(found), 1);
    pulse_reset();
    cyc();
    chk("post_rst_busy", int'(bus0.busy), 0);

    // run-count saturation: continuous tc=1 for well over 20 completed runs
    drive(1, 0, 1, 1);
    cyc();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 90; i++) cyc();
`ifdef CNTR_SEQ_RUNCNT_EN
    chk("runs_sat_g2", int'(n0), 15);
    chk("runs_sat_g0", int'(n1), 15);
`endif
    drive(0, 1, 0, 0);
    cyc();
    drive(1, 0, 0, 4);
    cyc();
`ifdef CNTR_SEQ_RUNCNT_EN
    chk("runs_clr_g2", int'(n0), 0);
`endif
    drive(0, 1, 0, 0);
    cyc();

    // randomized traffic against the reference models
    for (int i = 0; i < 500; i++) begin
      int tcv;
      tcv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), tcv);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/cntr_seq.md
Name: cntr_seq

Overview:
- Sequencer for the 4-bit counter datapath: arms, runs, terminates and re-arms a counter against a programmable terminal count.
- Supports one-shot and continuous modes, an abort input, and an inter-run gap.
- Sits between the control logic that issues start/stop and the downstream logic that consumes count bits and the done pulse.
- Bus values use individual bit ports, MSB first.

Parameters:
- TC_DEFAULT, 15, terminal count held in tc_r after reset (0..15).
- GAP, 2, idle cycles in continuous mode between reaching terminal count and restarting at 0 (0..15).

Ports:
- c  input  1  clock, all state updates on posedge.
- r  input  1  reset; asynchronous, active-high.
- start  input  1  request a run; sampled only in IDLE.
- stop  input  1  abort the current run.
- mode  input  1  0 = one-shot, 1 = continuous; captured with start.
- tc_3_..tc_0_  input  1 each  terminal count; captured with start.
- o_3_..o_0_  output  1 each  current count (cnt register).
- busy  output  1  high in RUN or GAP.
- done  output  1  one-cycle pulse, high in the cycle o equals tc_r during RUN.

Behaviour:
- Reset (r=1, async): state=IDLE, cnt=0, tc_r=TC_DEFAULT, mode_r=0, gap counter=0, busy=0, done=0. Outputs change immediately on reset, with no clock edge needed. Reset mid-run aborts with no done pulse.
- States: IDLE, RUN, GAP. busy is registered and equals (next state != IDLE).
- IDLE, start=1 and stop=0 at edge k:
  - tc_r<=tc, mode_r<=mode, cnt<=0, state<=RUN.
  - done<=1 at edge k if tc=0.
- IDLE otherwise: all registers hold, so o keeps its last value.
- RUN, cnt!=tc_r: cnt<=cnt+1 (4-bit, mod 16).
- done<=1 exactly when the new cnt equals tc_r and the next state is RUN; otherwise done<=0. For a start at edge k, o=tc_r and done=1 after edge k+tc_r.
- RUN, cnt==tc_r:
  - mode_r=0: state<=IDLE, cnt holds at tc_r.
  - mode_r=1, GAP>0: state<=GAP, gap counter<=GAP-1, cnt holds.
  - mode_r=1, GAP=0: cnt<=0, stay in RUN. A new run starts immediately; done pulses again when cnt reaches tc_r (every cycle if tc_r=0).
- GAP: gap counter decrements each edge while cnt holds. At gap counter=0, cnt<=0 and state<=RUN, with done applied per the RUN rule. Net gap with o=tc_r is GAP cycles after the done cycle.
- stop=1 in RUN or GAP: state<=IDLE next edge, cnt holds, done<=0. stop wins over terminal count, gap expiry and start.
- start while busy: ignored. tc and mode changes while busy are ignored (captured values only).
- stop=1 in IDLE: no effect. start and stop both high in IDLE: stays IDLE.
- tc_r=15 in continuous mode: cnt reaches 15 and restarts at 0 via the normal path, never via natural overflow.

Optional Feature:
- Macro: CNTR_SEQ_RUNCNT_EN.
- With the macro defined:
  - Adds outputs n_3_..n_0_: count of completed runs (done pulses), saturating at 15.
  - Cleared to 0 by r and on each accepted start.
  - Increments on the edge following each done pulse.
- Without the macro: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: r pulse mid-cycle -> o=0000, busy=0 and done=0 immediately; tc_r=15.
- One-shot tc=5: start at edge k -> o steps 0..5, done=1 only after edge k+5, busy=0 after edge k+6, o held at 5.
- Continuous tc=3, GAP=2: o sequence 0,1,2,3,3,3,0,1,... with done high on each first 3; busy stays 1.
- tc=0 one-shot: done=1 after the start edge, IDLE on the next edge. Continuous with GAP=0: done high every cycle, o=0.
- Abort: stop at cnt=7 of a tc=12 run -> IDLE next edge, o holds 7, no done; start in the same cycle ignored; new start restarts from 0.
- Async reset while o=9 in continuous mode -> immediate clear. With CNTR_SEQ_RUNCNT_EN: n saturates at 15 after 20 runs of tc=1, and is cleared by start.
